// File: rtl/mul_acc.sv
// Sequential signed multiply-accumulate: result = multiplicand * multiplier + addend.
// Radix-2 shift-add over operand magnitudes, with sign fix-up and accumulate in an epilogue cycle.
module mul_acc #(
    parameter int unsigned A_WIDTH = 64,
    parameter int unsigned B_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    output logic               ready,
    input  logic [A_WIDTH-1:0] multiplicand,
    input  logic [B_WIDTH-1:0] multiplier,
    input  logic [B_WIDTH-1:0] addend,
    output logic [A_WIDTH-1:0] result,
    output logic               valid_out,
    output logic               overflow
);

    localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int unsigned F_WIDTH = P_WIDTH + 1;
    localparam int unsigned CNT_W   = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StInit, StLoop, StEpilogue} state_e;

    state_e state_q, state_d;

    logic [A_WIDTH-1:0] a_q, ma_q, result_q;
    logic [B_WIDTH-1:0] b_q, c_q, mb_q;
    logic [P_WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q, overflow_q, valid_out_q;

    logic [P_WIDTH-1:0] ma_shifted;
    logic [F_WIDTH-1:0] acc_signed, c_ext, full;
    logic               full_ovf;

    always_comb begin
        ma_shifted = {{B_WIDTH{1'b0}}, ma_q} << cnt_q;
        acc_signed = sign_q ? -{1'b0, acc_q} : {1'b0, acc_q};
        c_ext      = {{(F_WIDTH - B_WIDTH){c_q[B_WIDTH-1]}}, c_q};
        full       = acc_signed + c_ext;
        // Representable iff the bits above the result all equal its sign bit.
        full_ovf   = full != {{(F_WIDTH - A_WIDTH){full[A_WIDTH-1]}}, full[A_WIDTH-1:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (valid_in) state_d = StInit;
            StInit:     state_d = StLoop;
            StLoop:     if (cnt_q == CNT_W'(B_WIDTH - 1)) state_d = StEpilogue;
            StEpilogue: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= (state_q == StEpilogue);
            unique case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        a_q <= multiplicand;
                        b_q <= multiplier;
                        c_q <= addend;
                    end
                end
                StInit: begin
                    // Negating the most-negative value yields 2^(W-1), correct as unsigned.
                    ma_q   <= a_q[A_WIDTH-1] ? -a_q : a_q;
                    mb_q   <= b_q[B_WIDTH-1] ? -b_q : b_q;
                    acc_q  <= '0;
                    sign_q <= a_q[A_WIDTH-1] ^ b_q[B_WIDTH-1];
                    cnt_q  <= '0;
                end
                StLoop: begin
                    if (mb_q[0]) acc_q <= acc_q + ma_shifted;
                    mb_q  <= mb_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                end
                StEpilogue: begin
                    result_q   <= full[A_WIDTH-1:0];
                    overflow_q <= full_ovf;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ready     = (state_q == StIdle);
        result    = result_q;
        overflow  = overflow_q;
        valid_out = valid_out_q;
    end

endmodule

// File: tb/tb_mul_acc.sv
// Directed self-checking bench for mul_acc with hand-computed expected results.
module tb_mul_acc;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready;
    logic [63:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] addend;
    logic [63:0] result;
    logic        valid_out;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    mul_acc #(.A_WIDTH(64), .B_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .ready        (ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .result       (result),
        .valid_out    (valid_out),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [63:0] exp_r, input logic exp_o);
        int lat;
        bit seen;
        @(negedge clk);
        valid_in     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        check_eq({tag, " ready_before"}, 64'(ready), 64'd1);
        @(posedge clk);
        #1;
        valid_in     = 1'b0;
        multiplicand = '1;
        multiplier   = '1;
        addend       = '1;
        check_eq({tag, " busy"}, 64'(ready), 64'd0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid_out) seen = 1'b1;
        end
        check_eq({tag, " latency"}, 64'(lat), 64'd34);
        check_eq({tag, " result"}, result, exp_r);
        check_eq({tag, " overflow"}, 64'(overflow), 64'(exp_o));
        @(posedge clk);
        #1;
        check_eq({tag, " pulse_end"}, 64'(valid_out), 64'd0);
        check_eq({tag, " hold"}, result, exp_r);
    endtask

    initial begin
        int accepts;
        int pulses;
        reset        = 1'b1;
        valid_in     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst ready", 64'(ready), 64'd1);
        check_eq("rst valid_out", 64'(valid_out), 64'd0);
        check_eq("rst result", result, 64'd0);
        check_eq("rst overflow", 64'(overflow), 64'd0);

        run_op("pp", 64'd100, 32'd7, 32'd3, 64'd703, 1'b0);
        run_op("np", -64'sd100, 32'd7, -32'sd3, -64'sd703, 1'b0);
        run_op("pn", 64'd100, -32'sd7, 32'd3, -64'sd697, 1'b0);
        run_op("nn", -64'sd100, -32'sd7, 32'd0, 64'd700, 1'b0);
        run_op("b0", 64'd12345, 32'd0, -32'sd5, -64'sd5, 1'b0);
        run_op("minneg", 64'h8000_0000_0000_0000, -32'sd1, 32'd0,
               64'h8000_0000_0000_0000, 1'b1);
        run_op("big", 64'h0000_0100_0000_0000, 32'h4000_0000, 32'd0, 64'd0, 1'b1);
        run_op("edge", 64'hC000_0000_0000_0000, 32'd2, 32'd0,
               64'h8000_0000_0000_0000, 1'b0);

        // valid_in held for 40 cycles: only two accepts, two result pulses.
        accepts = 0;
        pulses  = 0;
        multiplicand = 64'd3;
        multiplier   = 32'd5;
        addend       = 32'd1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            valid_in = (i < 40);
            if (valid_in && ready) accepts++;
            if (valid_out) pulses++;
        end
        valid_in = 1'b0;
        check_eq("hold accepts", 64'(accepts), 64'd2);
        check_eq("hold pulses", 64'(pulses), 64'd2);
        check_eq("hold result", result, 64'd16);

        // Reset mid-loop aborts the operation.
        @(negedge clk);
        valid_in     = 1'b1;
        multiplicand = 64'd9;
        multiplier   = 32'd9;
        addend       = 32'd0;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("abort ready", 64'(ready), 64'd1);
        check_eq("abort result", result, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) pulses++;
        end
        check_eq("abort pulses", 64'(pulses), 64'd0);
        run_op("after", 64'd6, 32'd7, 32'd0, 64'd42, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
